// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection and EX/MEM, MEM/WB
// operand forwarding feeding the ALU.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              hazard_stall,
  output logic [DATA_W-1:0] lvalue,
  output logic [DATA_W-1:0] rvalue,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_dest,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic [OP_W-1:0]   alu_op;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t ex_d;
  id_ex_t cap;

  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_W-1:0]  spec,
    input logic [DATA_W-1:0] rf,
    input logic              xwe,
    input logic [REG_W-1:0]  xrd,
    input logic [DATA_W-1:0] xres,
    input logic              wwe,
    input logic [REG_W-1:0]  wrd,
    input logic [DATA_W-1:0] wres
  );
    logic xhit;
    logic whit;
    xhit = xwe && (xrd != '0) && (xrd == spec);
    whit = wwe && (wrd != '0) && (wrd == spec);
    if (xhit)      return xres;
    else if (whit) return wres;
    else           return rf;
  endfunction

  always_comb begin
    cap            = '0;
    cap.valid      = id_valid;
    cap.reg_write  = id_valid & id_reg_write;
    cap.mem_read   = id_valid & id_mem_read;
    cap.mem_write  = id_valid & id_mem_write;
    cap.mem_to_reg = id_valid & id_mem_to_reg;
    cap.alu_src    = id_alu_src;
    cap.alu_op     = id_alu_op;
    cap.rs         = id_rs;
    cap.rt         = id_rt;
    cap.dest       = id_reg_dst ? id_rd : id_rt;
    cap.rs_data    = id_rs_data;
    cap.rt_data    = id_rt_data;
    cap.imm        = id_imm;
  end

  always_comb begin
    hazard_stall = ex_q.valid & ex_q.mem_read
                 & (ex_q.dest != '0)
                 & ((ex_q.dest == id_rs) | (ex_q.dest == id_rt))
                 & id_valid;
  end

  // flush beats stall, stall beats the load-use bubble
  always_comb begin
    ex_d = ex_q;
    priority case (1'b1)
      flush:        ex_d = '0;
      stall:        ex_d = ex_q;
      hazard_stall: ex_d = '0;
      default:      ex_d = cap;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  always_comb begin
    fwd_rs = fwd(ex_q.rs, ex_q.rs_data,
                 exmem_reg_write, exmem_rd, exmem_result,
                 memwb_reg_write, memwb_rd, memwb_result);
    fwd_rt = fwd(ex_q.rt, ex_q.rt_data,
                 exmem_reg_write, exmem_rd, exmem_result,
                 memwb_reg_write, memwb_rd, memwb_result);
  end

  assign lvalue        = fwd_rs;
  assign rvalue        = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_op        = ex_q.alu_op;
  assign ex_dest       = ex_q.dest;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table through a scoreboard queue,
// then hand sequences for hazard, stall/flush, r0 and async reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_reg_dst;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        hazard_stall;
  logic [31:0] lvalue, rvalue, ex_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  ex_dest;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic        ex_mem_write, ex_mem_to_reg;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result),
    .hazard_stall(hazard_stall), .lvalue(lvalue),
    .rvalue(rvalue), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [3:0]  op;
    logic        src, dst, rw;
    logic        xwe;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic [31:0] e_l, e_r, e_st;
    logic [4:0]  e_dest;
    logic        e_valid, e_rw;
  } vec_t;

  typedef struct {
    logic [31:0] l, r, st;
    logic [4:0]  dest;
    logic [3:0]  op;
    logic        valid, rw;
  } exp_t;

  vec_t tbl[9];
  exp_t sb[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic v, input logic [4:0] rs, rt, rd,
    input logic [31:0] rsd, rtd, imm, input logic [3:0] op,
    input logic src, dst, rw,
    input logic xwe, input logic [4:0] xrd, input logic [31:0] xres,
    input logic wwe, input logic [4:0] wrd, input logic [31:0] wres,
    input logic [31:0] el, er, est, input logic [4:0] ed,
    input logic ev, erw);
    vec_t t;
    t.valid = v; t.rs = rs; t.rt = rt; t.rd = rd;
    t.rsd = rsd; t.rtd = rtd; t.imm = imm; t.op = op;
    t.src = src; t.dst = dst; t.rw = rw;
    t.xwe = xwe; t.xrd = xrd; t.xres = xres;
    t.wwe = wwe; t.wrd = wrd; t.wres = wres;
    t.e_l = el; t.e_r = er; t.e_st = est; t.e_dest = ed;
    t.e_valid = ev; t.e_rw = erw;
    return t;
  endfunction

  task automatic drive_id(
    input logic v, input logic [4:0] rs, rt, rd,
    input logic [31:0] rsd, rtd, imm, input logic [3:0] op,
    input logic src, dst, rw, mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_alu_op = op; id_alu_src = src; id_reg_dst = dst;
    id_reg_write = rw; id_mem_read = mr;
    id_mem_write = 1'b0; id_mem_to_reg = mr;
  endtask

  task automatic fwd_off();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  initial begin
    exp_t e;
    vec_t t;
    tbl[0] = mk(1, 1, 2, 3, 32'h5, 32'h7, 0, 4'h0, 0, 1, 1,
                0, 0, 0, 0, 0, 0,
                32'h5, 32'h7, 32'h7, 3, 1, 1);
    tbl[1] = mk(1, 4, 2, 9, 32'h40, 32'h50, 0, 4'h1, 0, 1, 1,
                1, 4, 32'h11, 1, 4, 32'h22,
                32'h11, 32'h50, 32'h50, 9, 1, 1);
    tbl[2] = mk(1, 4, 2, 9, 32'h40, 32'h50, 0, 4'h1, 0, 1, 1,
                0, 4, 32'h11, 1, 4, 32'h22,
                32'h22, 32'h50, 32'h50, 9, 1, 1);
    tbl[3] = mk(1, 4, 2, 9, 32'h40, 32'h50, 0, 4'h1, 0, 1, 1,
                1, 0, 32'h11, 1, 0, 32'h22,
                32'h40, 32'h50, 32'h50, 9, 1, 1);
    tbl[4] = mk(1, 1, 6, 7, 32'h10, 32'h60, 32'hFFFF_FFF0, 4'h2,
                1, 1, 1, 1, 6, 32'h99, 0, 0, 0,
                32'h10, 32'hFFFF_FFF0, 32'h99, 7, 1, 1);
    tbl[5] = mk(1, 0, 3, 4, 32'h123, 32'h30, 0, 4'h3, 0, 1, 1,
                1, 0, 32'hDEAD, 1, 0, 32'hBEEF,
                32'h123, 32'h30, 32'h30, 4, 1, 1);
    tbl[6] = mk(0, 1, 2, 3, 32'h8, 32'h9, 0, 4'h0, 0, 1, 1,
                0, 0, 0, 0, 0, 0,
                32'h8, 32'h9, 32'h9, 3, 0, 0);
    tbl[7] = mk(1, 1, 12, 3, 32'h1, 32'h2, 0, 4'h5, 0, 0, 1,
                0, 0, 0, 0, 0, 0,
                32'h1, 32'h2, 32'h2, 12, 1, 1);
    tbl[8] = mk(1, 1, 13, 14, 32'h1, 32'h2, 0, 4'h0, 0, 1, 1,
                1, 5, 32'hAA, 1, 13, 32'hBB,
                32'h1, 32'hBB, 32'hBB, 14, 1, 1);

    rst_n = 0; stall = 0; flush = 0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fwd_off();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, ex_valid}, 0);
    check("rst_lvalue", lvalue, 0);
    check("rst_rvalue", rvalue, 0);
    check("rst_dest", {27'b0, ex_dest}, 0);
    check("rst_ctrl", {28'b0, ex_reg_write, ex_mem_read,
                       ex_mem_write, ex_mem_to_reg}, 0);
    rst_n = 1;

    foreach (tbl[i]) begin
      t = tbl[i];
      drive_id(t.valid, t.rs, t.rt, t.rd, t.rsd, t.rtd, t.imm,
               t.op, t.src, t.dst, t.rw, 0);
      e.l = t.e_l; e.r = t.e_r; e.st = t.e_st; e.dest = t.e_dest;
      e.op = t.op; e.valid = t.e_valid; e.rw = t.e_rw;
      sb.push_back(e);
      @(posedge clk);
      #1;
      exmem_reg_write = t.xwe; exmem_rd = t.xrd;
      exmem_result = t.xres;
      memwb_reg_write = t.wwe; memwb_rd = t.wrd;
      memwb_result = t.wres;
      #1;
      if (sb.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_lvalue", i), lvalue, e.l);
        check($sformatf("v%0d_rvalue", i), rvalue, e.r);
        check($sformatf("v%0d_store", i), ex_store_data, e.st);
        check($sformatf("v%0d_dest", i), {27'b0, ex_dest}, {27'b0, e.dest});
        check($sformatf("v%0d_op", i), {28'b0, alu_op}, {28'b0, e.op});
        check($sformatf("v%0d_valid", i), {31'b0, ex_valid}, {31'b0, e.valid});
        check($sformatf("v%0d_rw", i), {31'b0, ex_reg_write}, {31'b0, e.rw});
      end
      fwd_off();
    end

    // load-use: lw r8 then consumer of r8
    drive_id(1, 1, 8, 0, 0, 0, 32'h4, 0, 1, 0, 1, 1);
    @(posedge clk); #1;
    check("lu_load_memrd", {31'b0, ex_mem_read}, 1);
    drive_id(1, 8, 2, 9, 32'h0, 32'h3, 0, 0, 0, 1, 1, 0);
    #1;
    check("lu_hazard_on", {31'b0, hazard_stall}, 1);
    @(posedge clk); #1;
    check("lu_bubble_valid", {31'b0, ex_valid}, 0);
    check("lu_bubble_rw", {31'b0, ex_reg_write}, 0);
    check("lu_hazard_off", {31'b0, hazard_stall}, 0);
    @(posedge clk); #1;
    memwb_reg_write = 1; memwb_rd = 8; memwb_result = 32'h77;
    #1;
    check("lu_dep_valid", {31'b0, ex_valid}, 1);
    check("lu_dep_fwd", lvalue, 32'h77);
    fwd_off();

    // stall holds for 3 cycles despite new decode inputs
    drive_id(1, 1, 2, 5, 32'hAA, 32'hBB, 0, 4'h6, 0, 1, 1, 0);
    @(posedge clk); #1;
    stall = 1;
    drive_id(1, 3, 4, 6, 32'h1, 32'h2, 0, 4'h7, 0, 1, 1, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_l", c), lvalue, 32'hAA);
      check($sformatf("stall%0d_r", c), rvalue, 32'hBB);
      check($sformatf("stall%0d_op", c), {28'b0, alu_op}, 32'h6);
      check($sformatf("stall%0d_dest", c), {27'b0, ex_dest}, 32'h5);
    end
    flush = 1;
    @(posedge clk); #1;
    check("flush_valid", {31'b0, ex_valid}, 0);
    check("flush_lvalue", lvalue, 0);
    check("flush_dest", {27'b0, ex_dest}, 0);
    stall = 0; flush = 0;

    // load to r0 never raises a hazard
    drive_id(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    @(posedge clk); #1;
    drive_id(1, 0, 0, 9, 0, 0, 0, 0, 0, 1, 1, 0);
    #1;
    check("r0_memrd", {31'b0, ex_mem_read}, 1);
    check("r0_no_hazard", {31'b0, hazard_stall}, 0);

    // async reset mid-cycle
    drive_id(1, 1, 2, 3, 32'h55, 32'h66, 0, 4'h1, 0, 1, 1, 0);
    @(posedge clk); #1;
    check("ar_pre_l", lvalue, 32'h55);
    #2 rst_n = 0;
    #1;
    check("ar_valid", {31'b0, ex_valid}, 0);
    check("ar_lvalue", lvalue, 0);
    check("ar_dest", {27'b0, ex_dest}, 0);
    check("ar_op", {28'b0, alu_op}, 0);
    rst_n = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end

endmodule
